cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU sequencer: FETCH, DECODE, MEM, WB and HALT.
// Owns PC, IR and MDR and runs the memory request handshake.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  input  logic [1:0]  nextPCSel,
  input  logic        memWE,
  input  logic        dAddrSel,
  input  logic        regFileWE,
  input  logic [15:0] instrData,
  input  logic [15:0] rs1_data,
  input  logic [15:0] rs2_data,
  output logic [15:0] pc,
  output logic        rf_we,
  output logic [15:0] mdr,
  input  logic        halt_req,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mdr_q, mdr_d;
  logic        req_en_q, req_en_d;
  logic        ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      mdr_q    <= 16'h0000;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      req_en_q <= req_en_d;
    end
  end

  // req_en_q holds the first fetch off until one edge after reset release
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    req_en_d  = 1'b1;
    mem_req   = 1'b0;
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = rs2_data;
    rf_we     = 1'b0;
    ack       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = req_en_q;
        ack     = req_en_q & mem_ack;
        if (ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (memWE || dAddrSel) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = dAddrSel ? rs1_data : instrData;
        mem_we   = memWE;
        ack      = mem_ack;
        if (ack) begin
          if (!memWE) begin
            mdr_d = mem_rdata;
          end
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we = regFileWE;
        unique case (nextPCSel)
          2'b01:   pc_d = instrData;
          2'b10:   pc_d = rs1_data;
          default: pc_d = pc_q + 16'd1;
        endcase
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt_req) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign mdr         = mdr_q;
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model walks each
// instruction through its phases and checks the outputs every cycle.
module tb_cpu_sequencer;

  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] MEM    = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  typedef struct {
    logic [15:0] ir;
    logic [1:0]  sel;
    logic        memwe;
    logic        daddr;
    logic        rfwe;
    logic [15:0] idata;
    logic [15:0] rs1;
    logic [15:0] rs2;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  nextPCSel = '0;
  logic        memWE = 1'b0;
  logic        dAddrSel = 1'b0;
  logic        regFileWE = 1'b0;
  logic [15:0] instrData = '0;
  logic [15:0] rs1_data = '0;
  logic [15:0] rs2_data = '0;
  logic        halt_req = 1'b0;

  logic        mem_req, mem_we, rf_we, halted;
  logic [15:0] mem_addr, mem_wdata, instruction, pc, mdr;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  logic [15:0] mpc = RPC;
  logic [15:0] mir = '0;
  logic [15:0] mmdr = '0;

  cpu_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instruction(instruction),
    .nextPCSel(nextPCSel), .memWE(memWE),
    .dAddrSel(dAddrSel), .regFileWE(regFileWE),
    .instrData(instrData),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .rf_we(rf_we), .mdr(mdr),
    .halt_req(halt_req), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic expect_cycle(input logic [2:0] st, input logic rq,
                              input logic [15:0] ad, input logic wr,
                              input logic [15:0] wd, input logic rf);
    chk("state", 16'(state), 16'(st));
    chk("mem_req", 16'(mem_req), 16'(rq));
    chk("mem_we", 16'(mem_we), 16'(rq & wr));
    if (rq) chk("mem_addr", mem_addr, ad);
    if (rq && wr) chk("mem_wdata", mem_wdata, wd);
    chk("rf_we", 16'(rf_we), 16'(rf));
    chk("halted", 16'(halted), 16'(st == HALT));
    chk("pc", pc, mpc);
    chk("instruction", instruction, mir);
    chk("mdr", mdr, mmdr);
  endtask

  // Async reset pulse; a late ack is held through reset and the
  // first cycle after release, where it must be ignored.
  task automatic reset_pulse();
    mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mpc  = RPC;
    mir  = '0;
    mmdr = '0;
    chk("rst_state", 16'(state), 16'(FETCH));
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_rf_we", 16'(rf_we), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_pc", pc, RPC);
    chk("rst_ir", instruction, 16'h0000);
    chk("rst_mdr", mdr, 16'h0000);
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_cycle(FETCH, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic run_instr(input instr_t t, input int wf, input int wm,
                           input logic [15:0] ld, input bit hw,
                           input int hc, input int ra);
    logic is_mem;
    is_mem = t.memwe | t.daddr;
    for (int k = 0; k <= wf; k++) begin
      expect_cycle(FETCH, 1'b1, mpc, 1'b0, '0, 1'b0);
      mem_ack   = (k == wf);
      mem_rdata = (k == wf) ? t.ir : 16'($urandom);
      halt_req  = 1'($urandom);
      @(negedge clk);
    end
    mir       = t.ir;
    nextPCSel = t.sel;
    memWE     = t.memwe;
    dAddrSel  = t.daddr;
    regFileWE = t.rfwe;
    instrData = t.idata;
    rs1_data  = t.rs1;
    rs2_data  = t.rs2;
    #1;
    expect_cycle(DECODE, 1'b0, '0, 1'b0, '0, 1'b0);
    mem_ack  = 1'($urandom);
    halt_req = 1'($urandom);
    @(negedge clk);
    if (is_mem) begin
      for (int k = 0; k <= wm; k++) begin
        expect_cycle(MEM, 1'b1, t.daddr ? t.rs1 : t.idata,
                     t.memwe, t.rs2, 1'b0);
        if (k == ra) begin
          reset_pulse();
          return;
        end
        mem_ack   = (k == wm);
        mem_rdata = (k == wm) ? ld : 16'($urandom);
        halt_req  = 1'($urandom);
        @(negedge clk);
      end
      if (!t.memwe) mmdr = ld;
    end
    expect_cycle(WB, 1'b0, '0, 1'b0, '0, t.rfwe);
    mem_ack  = 1'($urandom);
    halt_req = hw;
    @(negedge clk);
    case (t.sel)
      2'b01:   mpc = t.idata;
      2'b10:   mpc = t.rs1;
      default: mpc = mpc + 16'd1;
    endcase
    if (hw) begin
      for (int k = 0; k < hc; k++) begin
        expect_cycle(HALT, 1'b0, '0, 1'b0, '0, 1'b0);
        mem_ack  = 1'($urandom);
        halt_req = (k != hc - 1);
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
  endtask

  function automatic instr_t mk(input logic [15:0] ir,
                                input logic [1:0] sel,
                                input logic memwe, input logic daddr,
                                input logic rfwe,
                                input logic [15:0] idata,
                                input logic [15:0] rs1,
                                input logic [15:0] rs2);
    instr_t t;
    t.ir = ir; t.sel = sel; t.memwe = memwe; t.daddr = daddr;
    t.rfwe = rfwe; t.idata = idata; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  initial begin
    instr_t t;
    int wf, wm, hc, ra;
    bit hw;
    reset_pulse();

    // LDI, zero-wait
    t = mk(16'h1001, 2'b00, 0, 0, 1, 16'h0005, 16'h0, 16'h0);
    run_instr(t, 0, 0, 16'h0, 0, 0, -1);
    chk("pc_ldi", pc, 16'h0001);
    // ST via rs1, ack after 2 wait cycles
    t = mk(16'h2002, 2'b00, 1, 1, 0, 16'h0999, 16'h0040, 16'hBEEF);
    run_instr(t, 0, 2, 16'hDEAD, 0, 0, -1);
    chk("st_mdr_keep", mdr, 16'h0000);
    chk("pc_st", pc, 16'h0002);
    // LDR via rs1
    t = mk(16'h3003, 2'b00, 0, 1, 1, 16'h0777, 16'h0010, 16'h0);
    run_instr(t, 1, 0, 16'h1234, 0, 0, -1);
    chk("mdr_ldr", mdr, 16'h1234);
    chk("pc_ldr", pc, 16'h0003);
    // BRI, BRR, wrap
    t = mk(16'h4004, 2'b01, 0, 0, 0, 16'h0080, 16'h1111, 16'h0);
    run_instr(t, 0, 0, 16'h0, 0, 0, -1);
    chk("pc_bri", pc, 16'h0080);
    t = mk(16'h5005, 2'b10, 0, 0, 0, 16'h2222, 16'h0200, 16'h0);
    run_instr(t, 0, 0, 16'h0, 0, 0, -1);
    chk("pc_brr", pc, 16'h0200);
    t = mk(16'h6006, 2'b01, 0, 0, 0, 16'hFFFF, 16'h0, 16'h0);
    run_instr(t, 0, 0, 16'h0, 0, 0, -1);
    t = mk(16'h7007, 2'b00, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    run_instr(t, 0, 0, 16'h0, 0, 0, -1);
    chk("pc_wrap", pc, 16'h0000);
    // reserved select, then halt for 3 cycles
    t = mk(16'h8008, 2'b11, 0, 0, 0, 16'h3333, 16'h4444, 16'h0);
    run_instr(t, 0, 0, 16'h0, 1, 3, -1);
    chk("pc_halt", pc, 16'h0001);
    // reset while MEM awaits ack
    t = mk(16'h9009, 2'b00, 1, 0, 0, 16'h0050, 16'h0, 16'h5555);
    run_instr(t, 0, 3, 16'h0, 0, 0, 1);
    chk("pc_after_rst", pc, RPC);
    chk("addr_after_rst", mem_addr, RPC);

    for (int n = 0; n < 300; n++) begin
      t = mk(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      hw = ($urandom_range(0, 7) == 0);
      hc = $urandom_range(1, 3);
      ra = -1;
      if ((t.memwe | t.daddr) && $urandom_range(0, 19) == 0)
        ra = $urandom_range(0, wm);
      run_instr(t, wf, wm, 16'($urandom), hw, hc, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
